// File: rtl/rob_commit_buffer.sv
// Reorder buffer commit stage: in-order allocate from rename, out-of-order completion,
// in-order single-entry retirement. All state advances on the falling clock edge.
module rob_commit_buffer #(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned WIDTH = 170
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       STALL,
  input  logic                       FLUSH,
  input  logic                       entry_allocate_ROB,
  input  logic [WIDTH-1:0]           entry_ROB,
  input  logic [4:0]                 alloc_arch_reg,
  input  logic                       complete_flag,
  input  logic [$clog2(DEPTH)-1:0]   complete_idx,
  output logic                       rob_halt,
  output logic [$clog2(DEPTH)-1:0]   rob_tail_idx,
  output logic [$clog2(DEPTH):0]     rob_count,
  output logic                       rob_empty,
  output logic                       commit_valid,
  output logic                       commit_regwr,
  output logic [4:0]                 commit_arch_reg,
  output logic [5:0]                 commit_phys_reg,
  output logic [31:0]                commit_instrpc,
  output logic                       overflow_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  // Only the retirement-relevant fields are kept per entry; the rest of the payload is not consumed here.
  logic unused_payload;
  assign unused_payload = ^{entry_ROB[WIDTH-1:94], entry_ROB[92:82], entry_ROB[11:0]};

  logic [31:0] pc_mem    [DEPTH];
  logic [5:0]  phys_mem  [DEPTH];
  logic [4:0]  arch_mem  [DEPTH];
  logic        regwr_mem [DEPTH];

  logic [DEPTH-1:0] valid_q, valid_d, done_q, done_d;
  logic [AW-1:0]    head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             commit_valid_q, commit_valid_d;
  logic             commit_regwr_q, commit_regwr_d;
  logic [4:0]       commit_arch_q, commit_arch_d;
  logic [5:0]       commit_phys_q, commit_phys_d;
  logic [31:0]      commit_pc_q, commit_pc_d;

  logic full_c, alloc_c, commit_c, ovf_c;

  assign full_c   = (count_q == CW'(DEPTH));
  assign alloc_c  = entry_allocate_ROB & ~STALL & ~FLUSH & ~full_c;
  assign ovf_c    = entry_allocate_ROB & ~STALL & ~FLUSH & full_c;
  assign commit_c = valid_q[head_q] & done_q[head_q] & ~STALL & ~FLUSH;

  // Payload storage needs no reset: valid bits gate every use.
  always_ff @(negedge CLK) begin
    if (alloc_c) begin
      pc_mem[tail_q]    <= entry_ROB[49:18];
      phys_mem[tail_q]  <= entry_ROB[17:12];
      arch_mem[tail_q]  <= alloc_arch_reg;
      regwr_mem[tail_q] <= entry_ROB[93] & (entry_ROB[81:50] != 32'd0);
    end
  end

  always_comb begin
    valid_d        = valid_q;
    done_d         = done_q;
    head_d         = head_q;
    tail_d         = tail_q;
    count_d        = count_q;
    ovf_d          = ovf_q;
    commit_valid_d = 1'b0;
    commit_regwr_d = commit_regwr_q;
    commit_arch_d  = commit_arch_q;
    commit_phys_d  = commit_phys_q;
    commit_pc_d    = commit_pc_q;
    if (FLUSH) begin
      valid_d = '0;
      done_d  = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      // Completion reads the current valid bit, so a same-cycle allocation cannot be completed.
      if (complete_flag && valid_q[complete_idx]) done_d[complete_idx] = 1'b1;
      if (commit_c) begin
        valid_d[head_q] = 1'b0;
        done_d[head_q]  = 1'b0;
        head_d          = head_q + AW'(1);
        commit_valid_d  = 1'b1;
        commit_regwr_d  = regwr_mem[head_q];
        commit_arch_d   = arch_mem[head_q];
        commit_phys_d   = phys_mem[head_q];
        commit_pc_d     = pc_mem[head_q];
      end
      if (alloc_c) begin
        valid_d[tail_q] = 1'b1;
        done_d[tail_q]  = 1'b0;
        tail_d          = tail_q + AW'(1);
      end
      if (ovf_c) ovf_d = 1'b1;
      case ({alloc_c, commit_c})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(negedge CLK or negedge RESET) begin
    if (!RESET) begin
      valid_q        <= '0;
      done_q         <= '0;
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      ovf_q          <= 1'b0;
      commit_valid_q <= 1'b0;
      commit_regwr_q <= 1'b0;
      commit_arch_q  <= '0;
      commit_phys_q  <= '0;
      commit_pc_q    <= '0;
    end else begin
      valid_q        <= valid_d;
      done_q         <= done_d;
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      ovf_q          <= ovf_d;
      commit_valid_q <= commit_valid_d;
      commit_regwr_q <= commit_regwr_d;
      commit_arch_q  <= commit_arch_d;
      commit_phys_q  <= commit_phys_d;
      commit_pc_q    <= commit_pc_d;
    end
  end

  // One slot of headroom covers the allocation already in flight from rename.
  assign rob_halt        = (count_q >= CW'(DEPTH - 1));
  assign rob_tail_idx    = tail_q;
  assign rob_count       = count_q;
  assign rob_empty       = (count_q == '0);
  assign commit_valid    = commit_valid_q;
  assign commit_regwr    = commit_regwr_q;
  assign commit_arch_reg = commit_arch_q;
  assign commit_phys_reg = commit_phys_q;
  assign commit_instrpc  = commit_pc_q;
  assign overflow_err    = ovf_q;

endmodule

// File: tb/tb_rob_commit_buffer.sv
// Randomized + directed bench for rob_commit_buffer: queue-based reference model and
// a commit scoreboard checked by an independent monitor.
module tb_rob_commit_buffer;
  localparam int DEPTH = 32;

  logic         CLK = 1'b0;
  logic         RESET, STALL, FLUSH, entry_allocate_ROB, complete_flag;
  logic [169:0] entry_ROB;
  logic [4:0]   alloc_arch_reg, complete_idx;
  logic         rob_halt, rob_empty, commit_valid, commit_regwr, overflow_err;
  logic [4:0]   rob_tail_idx, commit_arch_reg;
  logic [5:0]   rob_count, commit_phys_reg;
  logic [31:0]  commit_instrpc;

  rob_commit_buffer #(.DEPTH(DEPTH), .WIDTH(170)) dut (
    .CLK(CLK), .RESET(RESET), .STALL(STALL), .FLUSH(FLUSH),
    .entry_allocate_ROB(entry_allocate_ROB), .entry_ROB(entry_ROB),
    .alloc_arch_reg(alloc_arch_reg), .complete_flag(complete_flag),
    .complete_idx(complete_idx), .rob_halt(rob_halt), .rob_tail_idx(rob_tail_idx),
    .rob_count(rob_count), .rob_empty(rob_empty), .commit_valid(commit_valid),
    .commit_regwr(commit_regwr), .commit_arch_reg(commit_arch_reg),
    .commit_phys_reg(commit_phys_reg), .commit_instrpc(commit_instrpc),
    .overflow_err(overflow_err)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [4:0]  idx;
    logic [31:0] pc;
    logic [5:0]  mapc;
    logic [4:0]  arch;
    logic        regwr;
    bit          done;
  } ent_t;

  ent_t mq[$];
  ent_t sb[$];
  int   m_tail = 0;
  bit   m_ovf = 1'b0;
  bit   m_commit = 1'b0;
  int   checks = 0;
  int   passed = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [169:0] mk(input logic [31:0] pc, input logic [5:0] mapc,
                                      input logic [31:0] instr, input bit rgwrt);
    logic [169:0] e;
    for (int i = 0; i < 170; i++) e[i] = 1'($urandom);
    e[81:50] = instr;
    e[49:18] = pc;
    e[17:12] = mapc;
    e[93]    = rgwrt;
    return e;
  endfunction

  // Reference: program-ordered queue; commit decision uses done flags from before this edge.
  task automatic model_step();
    int   sz;
    bit   do_commit;
    ent_t n;
    m_commit = 1'b0;
    if (FLUSH) begin
      mq.delete();
      m_tail = 0;
      return;
    end
    sz = mq.size();
    do_commit = (sz > 0) && mq[0].done && !STALL;
    if (complete_flag)
      foreach (mq[i]) if (mq[i].idx == complete_idx) mq[i].done = 1'b1;
    if (do_commit) begin
      sb.push_back(mq[0]);
      void'(mq.pop_front());
      m_commit = 1'b1;
    end
    if (entry_allocate_ROB && !STALL) begin
      if (sz == DEPTH) m_ovf = 1'b1;
      else begin
        n.idx   = 5'(m_tail);
        n.pc    = entry_ROB[49:18];
        n.mapc  = entry_ROB[17:12];
        n.arch  = alloc_arch_reg;
        n.regwr = entry_ROB[93] && (entry_ROB[81:50] != 32'd0);
        n.done  = 1'b0;
        mq.push_back(n);
        m_tail = (m_tail + 1) % DEPTH;
      end
    end
  endtask

  task automatic check_state();
    int c;
    c = mq.size();
    chk("count", 64'(rob_count), 64'(c));
    chk("empty", 64'(rob_empty), 64'(c == 0));
    chk("halt", 64'(rob_halt), 64'(c >= DEPTH - 1));
    chk("tail", 64'(rob_tail_idx), 64'(m_tail));
    chk("ovf", 64'(overflow_err), 64'(m_ovf));
    chk("commit_valid", 64'(commit_valid), 64'(m_commit));
  endtask

  task automatic step(input bit a, input logic [169:0] e, input logic [4:0] ar,
                      input bit cf, input logic [4:0] ci, input bit st, input bit fl);
    entry_allocate_ROB = a; entry_ROB = e; alloc_arch_reg = ar;
    complete_flag = cf; complete_idx = ci; STALL = st; FLUSH = fl;
    @(negedge CLK);
    model_step();
    @(posedge CLK);
    check_state();
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, '0, 0, 0, 0, 0, 0);
  endtask

  task automatic check_reset_outputs();
    chk("rst_count", 64'(rob_count), 0);
    chk("rst_empty", 64'(rob_empty), 1);
    chk("rst_halt", 64'(rob_halt), 0);
    chk("rst_tail", 64'(rob_tail_idx), 0);
    chk("rst_ovf", 64'(overflow_err), 0);
    chk("rst_cvalid", 64'(commit_valid), 0);
    chk("rst_regwr", 64'(commit_regwr), 0);
    chk("rst_arch", 64'(commit_arch_reg), 0);
    chk("rst_phys", 64'(commit_phys_reg), 0);
    chk("rst_pc", 64'(commit_instrpc), 0);
  endtask

  // Monitor: every retire strobe is matched against the oldest expected commit.
  always @(posedge CLK) begin
    if (RESET === 1'b1 && commit_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        $display("FAIL unexpected_commit: pc %0h with no expected entry", commit_instrpc);
      end else begin
        chk("commit_pc", 64'(commit_instrpc), 64'(sb[0].pc));
        chk("commit_phys", 64'(commit_phys_reg), 64'(sb[0].mapc));
        chk("commit_arch", 64'(commit_arch_reg), 64'(sb[0].arch));
        chk("commit_regwr", 64'(commit_regwr), 64'(sb[0].regwr));
        void'(sb.pop_front());
      end
    end
  end

  initial begin
    RESET = 1'b0; STALL = 0; FLUSH = 0; entry_allocate_ROB = 0; complete_flag = 0;
    entry_ROB = '0; alloc_arch_reg = 0; complete_idx = 0;
    #12;
    check_reset_outputs();
    @(posedge CLK); RESET = 1'b1; #1;

    // In-order retirement from reverse-order completion
    step(1, mk(32'h100, 6'd33, 32'h1234, 1), 5'd1, 0, 0, 0, 0);
    step(1, mk(32'h104, 6'd34, 32'h2345, 1), 5'd2, 0, 0, 0, 0);
    step(1, mk(32'h108, 6'd35, 32'h3456, 0), 5'd3, 0, 0, 0, 0);
    step(0, '0, 0, 1, 5'd2, 0, 0);
    step(0, '0, 0, 1, 5'd1, 0, 0);
    step(0, '0, 0, 1, 5'd0, 0, 0);
    idle(5);

    // Zero instruction with rgwrt set must not write a register
    step(1, mk(32'h200, 6'd40, 32'h0, 1), 5'd7, 0, 0, 0, 0);
    step(0, '0, 0, 1, 5'(m_tail - 1), 0, 0);
    idle(3);

    // Completion under stall is retained; commit waits for stall release
    step(1, mk(32'h300, 6'd41, 32'h55, 1), 5'd9, 0, 0, 0, 0);
    step(0, '0, 0, 1, 5'(m_tail - 1), 1, 0);
    step(0, '0, 0, 0, 0, 1, 0);
    step(0, '0, 0, 0, 0, 1, 0);
    idle(3);

    // Allocate into empty + complete same index: completion ignored
    step(1, mk(32'h380, 6'd42, 32'h66, 1), 5'd4, 1, 5'(m_tail), 0, 0);
    idle(2);
    step(0, '0, 0, 1, 5'(m_tail - 1), 0, 0);
    idle(3);

    // Flush with five entries, two done
    for (int i = 0; i < 5; i++) step(1, mk(32'h400 + 32'(4 * i), 6'(i), 32'h77, 1), 5'(i), 0, 0, 0, 0);
    step(0, '0, 0, 1, 5'(m_tail - 3), 0, 0);
    step(0, '0, 0, 1, 5'(m_tail - 2), 0, 0);
    step(0, '0, 0, 0, 0, 0, 1);
    idle(2);

    // Fill to capacity, then one dropped allocate
    for (int i = 0; i < DEPTH + 1; i++)
      step(1, mk(32'h1000 + 32'(4 * i), 6'(i), 32'h88, 1), 5'(i), 0, 0, 0, 0);
    chk("full_count", 64'(rob_count), 64'(DEPTH));
    chk("full_ovf", 64'(overflow_err), 1);
    step(0, '0, 0, 0, 0, 0, 1);

    // Steady allocate/complete pairs wrapping the tail
    for (int i = 0; i < 40; i++) begin
      step(1, mk(32'h2000 + 32'(4 * i), 6'(i), 32'h99, 1), 5'(i),
           (i > 0), 5'(m_tail - 1), 0, 0);
      chk("pair_count_le2", 64'(rob_count <= 2), 1);
    end
    idle(4);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      bit a, cf, st, fl;
      logic [4:0] ci;
      a  = ($urandom_range(0, 3) != 0);
      st = ($urandom_range(0, 9) == 0);
      fl = ($urandom_range(0, 49) == 0);
      cf = ($urandom_range(0, 2) != 0);
      if (mq.size() > 0 && $urandom_range(0, 4) != 0)
        ci = mq[$urandom_range(0, mq.size() - 1)].idx;
      else ci = 5'($urandom);
      step(a, mk($urandom, 6'($urandom), ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom,
                 1'($urandom)), 5'($urandom), cf, ci, st, fl);
    end

    // Asynchronous reset mid-operation discards everything
    for (int i = 0; i < 4; i++) step(1, mk(32'h3000 + 32'(4 * i), 6'(i), 32'h11, 1), 5'(i), 0, 0, 0, 0);
    for (int i = 0; i < mq.size(); i++) step(0, '0, 0, 1, mq[i].idx, 1, 0);
    RESET = 1'b0;
    #2;
    check_reset_outputs();
    mq.delete(); sb.delete(); m_tail = 0; m_ovf = 1'b0; m_commit = 1'b0;
    RESET = 1'b1;
    idle(3);
    step(1, mk(32'h4000, 6'd50, 32'h22, 1), 5'd5, 0, 0, 0, 0);
    step(0, '0, 0, 1, 5'd0, 0, 0);
    idle(3);

    step(0, '0, 0, 0, 0, 0, 1);
    chk("scoreboard_drained", 64'(sb.size()), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/rob_commit_buffer.md
ROB_COMMIT_BUFFER -- requirements
Module: rob_commit_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 32, meaning number of entries (power of two).
REQ-002 SHALL have parameter WIDTH, default 170, meaning stored entry width, equal to the rename entry width.
REQ-003 CLK  input  1  single clock; all state updates on the falling edge, matching the rename stage.
REQ-004 RESET  input  1  asynchronous, active-low reset.
REQ-005 STALL  input  1  freezes allocation and commit.
REQ-006 FLUSH  input  1  discards all entries.
REQ-007 entry_allocate_ROB  input  1  allocate request from rename.
REQ-008 entry_ROB  input  WIDTH  entry payload: control [169:82], instr [81:50], instrpc [49:18], MAPC [17:12], MAPB [11:6], MAPA [5:0].
REQ-009 alloc_arch_reg  input  5  architectural destination of the allocating entry.
REQ-010 complete_flag  input  1  execution completion strobe.
REQ-011 complete_idx  input  log2(DEPTH)  ROB index being completed.
REQ-012 rob_halt  output  1  combinational back-pressure to rename.
REQ-013 rob_tail_idx  output  log2(DEPTH)  index the next allocation receives.
REQ-014 rob_count  output  log2(DEPTH)+1  occupied entries.
REQ-015 rob_empty  output  1  rob_count == 0.
REQ-016 commit_valid  output  1  one-cycle retire strobe.
REQ-017 commit_regwr  output  1  retiring entry writes a register.
REQ-018 commit_arch_reg  output  5  architectural register, to the RRAT.
REQ-019 commit_phys_reg  output  6  physical register (MAPC), to the RRAT.
REQ-020 commit_instrpc  output  32  PC of the retiring instruction.
REQ-021 overflow_err  output  1  sticky error flag.

Function
REQ-022 SHALL keep per entry: payload, arch reg, valid bit, done bit; head/tail pointers wrap modulo DEPTH.
REQ-023 Allocate when entry_allocate_ROB=1, STALL=0, FLUSH=0 and count<DEPTH: write at tail, valid=1, done=0, tail+1.
REQ-024 An allocate request while count==DEPTH SHALL be dropped, leave state unchanged, and set overflow_err=1 until reset.
REQ-025 rob_halt SHALL be 1 when count >= DEPTH-1, allowing for one registered allocation in flight.
REQ-026 complete_flag=1 SHALL set done at complete_idx if that entry is valid; completions to invalid entries SHALL be ignored; completions are recorded even under STALL.
REQ-027 Commit when head is valid, head is done, STALL=0 and FLUSH=0: register the commit outputs for one cycle, clear valid, head+1; at most one commit per cycle.
REQ-028 commit_regwr SHALL equal entry bit 93 (control rgwrt) AND instr != 0.
REQ-029 commit_valid SHALL be 0 in every cycle without a commit; the other commit outputs hold their last value.
REQ-030 A done set in cycle N SHALL make the entry commit-eligible no earlier than cycle N+1 (1-cycle completion-to-commit latency).
REQ-031 Simultaneous allocate and commit SHALL leave count unchanged; both take effect.
REQ-032 Allocate into an empty buffer plus complete of that index in the same cycle: the complete is ignored.
REQ-033 FLUSH=1 SHALL clear all valid/done bits, head=tail=count=0 and commit_valid=0, overriding allocate, complete and commit in that cycle; overflow_err is unaffected.

Reset
REQ-034 RESET=0 SHALL immediately force head=tail=count=0, all valid/done=0, commit_valid=0, commit_regwr=0, commit_arch_reg=0, commit_phys_reg=0, commit_instrpc=0, overflow_err=0; thus rob_empty=1, rob_halt=0, rob_tail_idx=0.
REQ-035 Reset asserted mid-operation SHALL discard all entries with no commit strobe; operation resumes on the first falling edge after release.

Verification
REQ-036 Allocate 3 entries (PC 0x100/0x104/0x108, MAPC 33/34/35, arch 1/2/3), complete idx 2,1,0 -> three commits in order 0x100, 0x104, 0x108 on consecutive cycles after idx 0 completes; commit_phys_reg 33,34,35.
REQ-037 Fill to 31 entries -> rob_halt=1; at 32 entries one more allocate -> dropped, overflow_err=1, count stays 32.
REQ-038 Run 40 allocate/complete/commit pairs -> tail wraps 31->0, commits remain in order, count never exceeds 2.
REQ-039 With 5 entries, two done, FLUSH=1 -> count=0, rob_empty=1, no commit_valid in that or the next cycle.
REQ-040 Head done and STALL=1 -> no commit; STALL=0 -> commit next cycle. A complete issued under STALL is retained.
REQ-041 Entry with instr=0 and rgwrt=1 commits -> commit_valid=1, commit_regwr=0.
